shop_controller: RTL
====================

# shop_controller

Player-facing purchase front end for the game datapath. It turns debounced button pulses into unit-buy and level-upgrade requests and runs the purchase/success handshake with the wallet. Successful unit buys are pushed into a 4-entry spawn queue, which the battlefield spawner drains. It sits directly upstream of the wallet (drives `purchase`/`unitCost`, consumes `buySucc`) and upstream of the spawner.

## Interface
- `DEPTH`, 4, spawn queue entries (power of two)
- `COST0`..`COST3`, 50/100/150/200, unit costs by type
- `UPCOST0`..`UPCOST2`, 200/400/800, upgrade cost at level 0/1/2
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `gameTick`  in  1  one-cycle pulse marking the wallet update cycle
- `btnSel`  in  1  pulse; advance cursor type, 3 wraps to 0
- `btnBuy`  in  1  pulse; buy unit at cursor
- `btnUpgrade`  in  1  pulse; buy next level
- `balance`  in  11  wallet balance, used for display only
- `level`  in  2  wallet level
- `maxed`  in  1  wallet at level 3
- `buySucc`  in  1  wallet result, valid the cycle after `gameTick` while `purchase` is high
- `purchase`  out  1  purchase request to wallet
- `unitCost`  out  13  cost presented with `purchase`
- `upgrade`  out  1  one-cycle pulse after a successful upgrade payment
- `cursor`  out  2  selected unit type
- `affordable`  out  4  registered: bit i = (`balance` >= COSTi)
- `busy`  out  1  FSM not IDLE
- `denied`  out  1  one-cycle pulse: request rejected
- `spawnValid`  out  1  queue non-empty
- `spawnType`  out  2  head entry type
- `spawnReady`  in  1  spawner pops when `spawnValid` and `spawnReady` are both high

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - `btnSel` increments `cursor` modulo 4.
  - `btnUpgrade` has priority over `btnBuy` when both arrive in the same cycle.
  - Upgrade with `maxed`=1: `denied` pulses, stay IDLE, wallet untouched.
  - Upgrade otherwise: latch kind=UP and cost=UPCOST[`level`], go to REQ.
  - Buy with queue count = DEPTH: `denied` pulses, no charge.
  - Buy otherwise: latch kind=UNIT, type=`cursor`, cost=COST[`cursor`], go to REQ.
- **REQ**
  - `purchase`=1; `unitCost` is held at the latched cost.
  - On a cycle with `gameTick`=1, go to RESP. `purchase` stays high through that cycle.
- **RESP**
  - `purchase`=0; sample `buySucc`, then return to IDLE.
  - On success with kind=UNIT: push the type into the queue.
  - On success with kind=UP: pulse `upgrade`.
  - On failure: pulse `denied`.
- All button inputs are ignored outside IDLE, including `btnSel`.
- Queue slot reservation: a buy is accepted only if count < DEPTH. Pops during REQ/RESP only free space, so the RESP push can never overflow.
- Queue push and pop in the same cycle: count unchanged, both take effect. Pop when empty is ignored.
- `unitCost` is 0 whenever `purchase`=0.
- Cost arithmetic: zero-extend to 13 bits; no subtraction is done locally.

## Timing
- Reset values:
  - FSM=IDLE, `cursor`=0, queue empty.
  - Outputs `purchase`, `unitCost`, `upgrade`, `denied`, `spawnValid`, `busy` = 0.
  - `spawnType`=0, `affordable`=0.
- All outputs are registered except `spawnValid`/`spawnType`, which are direct queue state with no combinational path from inputs.
- Button to `purchase` high: 1 cycle.
- REQ lasts until the next `gameTick`, which may be the first REQ cycle.
- `upgrade`, `denied` and the queue push occur in the cycle after RESP is entered.
- Early rejection: `denied` pulses the cycle after the button.
- `affordable` lags `balance` by 1 cycle.
- Reset mid-operation: `purchase` drops immediately (async); the pending transaction is abandoned and the queue is flushed.

## Structure
- `shop_pkg`: state enum; COST/UPCOST defaults; `cost_of(type)` and `upcost_of(level)` functions; widths (cost 13, type 2).
- One sub-module `spawn_fifo`: DEPTH×2-bit, count register, valid/ready pop, push input.
- FSM, cursor and `affordable` compare live in `shop_controller`.

## Test plan
- Reset, then `btnSel` ×5 -> `cursor`=1. Reset asserted mid-REQ -> `purchase`=0 and `busy`=0 in the same cycle.
- `cursor`=2, `btnBuy`, `gameTick` 3 cycles later, `buySucc`=1 -> `unitCost`=150 while `purchase` is high; then `spawnValid`=1, `spawnType`=2.
- `btnBuy` with `buySucc`=0 -> `denied` pulses once, queue unchanged, back to IDLE.
- 4 successful buys with `spawnReady`=0, then a 5th `btnBuy` -> `denied` next cycle, `purchase` never asserted. Then `spawnReady`=1 -> types pop in FIFO order.
- `level`=1: `btnUpgrade` and `btnBuy` in the same cycle -> `unitCost`=400, one `upgrade` pulse on success, no queue push. With `maxed`=1 -> immediate `denied`.
- `balance`=149 -> `affordable`=4'b0011; `balance`=200 -> 4'b1111, one cycle later.

Source files
------------

// File: rtl/shop_pkg.sv
// Shared types, default prices and widths for the shop front end.
package shop_pkg;

    localparam int COST_W = 13;
    localparam int TYPE_W = 2;

    localparam logic [COST_W-1:0] DEF_COST0   = 13'd50;
    localparam logic [COST_W-1:0] DEF_COST1   = 13'd100;
    localparam logic [COST_W-1:0] DEF_COST2   = 13'd150;
    localparam logic [COST_W-1:0] DEF_COST3   = 13'd200;
    localparam logic [COST_W-1:0] DEF_UPCOST0 = 13'd200;
    localparam logic [COST_W-1:0] DEF_UPCOST1 = 13'd400;
    localparam logic [COST_W-1:0] DEF_UPCOST2 = 13'd800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        KIND_UNIT = 1'b0,
        KIND_UP   = 1'b1
    } kind_t;

    function automatic logic [COST_W-1:0] cost_of(input logic [TYPE_W-1:0] t);
        case (t)
            2'd0:    cost_of = DEF_COST0;
            2'd1:    cost_of = DEF_COST1;
            2'd2:    cost_of = DEF_COST2;
            default: cost_of = DEF_COST3;
        endcase
    endfunction

    // Level 3 is never charged (maxed blocks it), so it maps to 0.
    function automatic logic [COST_W-1:0] upcost_of(input logic [1:0] lvl);
        case (lvl)
            2'd0:    upcost_of = DEF_UPCOST0;
            2'd1:    upcost_of = DEF_UPCOST1;
            2'd2:    upcost_of = DEF_UPCOST2;
            default: upcost_of = '0;
        endcase
    endfunction

endpackage

// File: rtl/spawn_fifo.sv
// Spawn queue: DEPTH entries of unit type, push from the shop, valid/ready pop by the spawner.
module spawn_fifo
    import shop_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [TYPE_W-1:0] push_type,
    input  logic              ready,
    output logic              valid,
    output logic [TYPE_W-1:0] head,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [TYPE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              pop;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = valid & ready;
    assign head  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads 0 when empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_type;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shop_controller.sv
// Shop front end: button pulses to wallet purchase handshake, with a spawn queue for bought units.
module shop_controller
    import shop_pkg::*;
#(
    parameter int                DEPTH   = 4,
    parameter logic [COST_W-1:0] COST0   = DEF_COST0,
    parameter logic [COST_W-1:0] COST1   = DEF_COST1,
    parameter logic [COST_W-1:0] COST2   = DEF_COST2,
    parameter logic [COST_W-1:0] COST3   = DEF_COST3,
    parameter logic [COST_W-1:0] UPCOST0 = DEF_UPCOST0,
    parameter logic [COST_W-1:0] UPCOST1 = DEF_UPCOST1,
    parameter logic [COST_W-1:0] UPCOST2 = DEF_UPCOST2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gameTick,
    input  logic        btnSel,
    input  logic        btnBuy,
    input  logic        btnUpgrade,
    input  logic [10:0] balance,
    input  logic [1:0]  level,
    input  logic        maxed,
    input  logic        buySucc,
    output logic        purchase,
    output logic [12:0] unitCost,
    output logic        upgrade,
    output logic [1:0]  cursor,
    output logic [3:0]  affordable,
    output logic        busy,
    output logic        denied,
    output logic        spawnValid,
    output logic [1:0]  spawnType,
    input  logic        spawnReady
);

    state_t              state, state_n;
    kind_t               kind_q, kind_n;
    logic [TYPE_W-1:0]   type_q, type_n;
    logic [COST_W-1:0]   cost_q, cost_n;
    logic [COST_W-1:0]   unit_price, up_price, bal_ext;
    logic [1:0]          cursor_n;
    logic                upgrade_n, denied_n, push, full;

    always_comb begin
        case (cursor)
            2'd0:    unit_price = COST0;
            2'd1:    unit_price = COST1;
            2'd2:    unit_price = COST2;
            default: unit_price = COST3;
        endcase
        case (level)
            2'd0:    up_price = UPCOST0;
            2'd1:    up_price = UPCOST1;
            2'd2:    up_price = UPCOST2;
            default: up_price = '0;
        endcase
    end

    always_comb begin
        state_n   = state;
        kind_n    = kind_q;
        type_n    = type_q;
        cost_n    = cost_q;
        cursor_n  = cursor;
        upgrade_n = 1'b0;
        denied_n  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (btnSel) cursor_n = cursor + 2'd1;
                if (btnUpgrade) begin
                    if (maxed) begin
                        denied_n = 1'b1;
                    end else begin
                        kind_n  = KIND_UP;
                        cost_n  = up_price;
                        state_n = REQ;
                    end
                end else if (btnBuy) begin
                    // Slot is reserved at accept time, so the later push cannot overflow.
                    if (full) begin
                        denied_n = 1'b1;
                    end else begin
                        kind_n  = KIND_UNIT;
                        type_n  = cursor;
                        cost_n  = unit_price;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (gameTick) state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
                if (!buySucc)             denied_n  = 1'b1;
                else if (kind_q == KIND_UP) upgrade_n = 1'b1;
                else                      push      = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bal_ext = {2'b00, balance};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            kind_q     <= KIND_UNIT;
            type_q     <= '0;
            cost_q     <= '0;
            cursor     <= '0;
            purchase   <= 1'b0;
            unitCost   <= '0;
            upgrade    <= 1'b0;
            denied     <= 1'b0;
            busy       <= 1'b0;
            affordable <= '0;
        end else begin
            state      <= state_n;
            kind_q     <= kind_n;
            type_q     <= type_n;
            cost_q     <= cost_n;
            cursor     <= cursor_n;
            purchase   <= (state_n == REQ);
            unitCost   <= (state_n == REQ) ? cost_n : '0;
            upgrade    <= upgrade_n;
            denied     <= denied_n;
            busy       <= (state_n != IDLE);
            affordable <= {bal_ext >= COST3, bal_ext >= COST2,
                           bal_ext >= COST1, bal_ext >= COST0};
        end
    end

    spawn_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_type (type_q),
        .ready     (spawnReady),
        .valid     (spawnValid),
        .head      (spawnType),
        .full      (full)
    );

endmodule
